// File: rtl/id_control_pipe_if.sv
// Handshake and control-bundle bundle between IF/ID, the ID control pipe and EX.
// master = environment side (drives instruction/handshake), slave = id_control_pipe.
interface id_control_pipe_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ILL_CNT_W  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           instr;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic                  RegWrite;
  logic                  ALUSrc;
  logic                  MemWrite;
  logic                  MemRead;
  logic                  Branch;
  logic                  MemToReg;
  logic [1:0]            ALUop;
  logic [REG_ADDR_W-1:0] rs1_q;
  logic [REG_ADDR_W-1:0] rs2_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  illegal_q;
  logic [ILL_CNT_W-1:0]  ill_cnt;

  modport master (
    output in_valid, instr, flush, out_ready,
    input  in_ready, out_valid, RegWrite, ALUSrc, MemWrite, MemRead, Branch, MemToReg,
    input  ALUop, rs1_q, rs2_q, rd_q, illegal_q, ill_cnt
  );

  modport slave (
    input  in_valid, instr, flush, out_ready,
    output in_ready, out_valid, RegWrite, ALUSrc, MemWrite, MemRead, Branch, MemToReg,
    output ALUop, rs1_q, rs2_q, rd_q, illegal_q, ill_cnt
  );
endinterface

// File: rtl/id_control_pipe.sv
// RV32I ID-stage control decode with ID/EX register, load-use stall, flush and illegal counter.
// Define CTRL_JUMP_EN to decode JAL/JALR/LUI/AUIPC instead of flagging them illegal.
module id_control_pipe #(
  parameter int unsigned OPCODE_W   = 7,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ILL_CNT_W  = 8
) (
  input logic               clk,
  input logic               rst,
  id_control_pipe_if.slave  bus
);

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic       mem_to_reg;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef enum logic [0:0] {StRun, StStall} state_e;

  state_e                state_q, state_d;
  ctrl_t                 ctrl_q, ctrl_d, dec_ctrl;
  logic                  valid_q, valid_d;
  logic                  illegal_q, illegal_d, dec_illegal;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [ILL_CNT_W-1:0]  ill_cnt_q, ill_cnt_d;

  logic [OPCODE_W-1:0]   opcode;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic                  uses_rs1, uses_rs2;
  logic                  hold, hazard, stall, in_ready, accept;
  logic                  unused_instr;

  assign opcode       = bus.instr[OPCODE_W-1:0];
  assign rs1          = bus.instr[15 +: REG_ADDR_W];
  assign rs2          = bus.instr[20 +: REG_ADDR_W];
  assign rd           = bus.instr[7 +: REG_ADDR_W];
  assign unused_instr = ^{bus.instr[31:25], bus.instr[14:12]};

  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    uses_rs1    = 1'b1;
    uses_rs2    = 1'b0;
    case (opcode)
      7'b0110011: begin dec_ctrl = 8'b1000_0010; uses_rs2 = 1'b1; end
      7'b0010011: dec_ctrl = 8'b1100_0011;
      7'b0000011: dec_ctrl = 8'b1101_0100;
      7'b0100011: begin dec_ctrl = 8'b0110_0000; uses_rs2 = 1'b1; end
      7'b1100011: begin dec_ctrl = 8'b0000_1001; uses_rs2 = 1'b1; end
`ifdef CTRL_JUMP_EN
      7'b1101111: begin dec_ctrl = 8'b1100_1000; uses_rs1 = 1'b0; end
      7'b1100111: dec_ctrl = 8'b1100_1000;
      7'b0110111: begin dec_ctrl = 8'b1100_0000; uses_rs1 = 1'b0; end
      7'b0010111: begin dec_ctrl = 8'b1100_0000; uses_rs1 = 1'b0; end
`endif
      default:    dec_illegal = 1'b1;
    endcase
  end

  // Load in ID/EX whose destination is a source of the instruction now in ID.
  assign hazard   = valid_q && ctrl_q.mem_read && (rd_q != '0) &&
                    ((uses_rs1 && (rd_q == rs1)) || (uses_rs2 && (rd_q == rs2)));
  assign hold     = valid_q && !bus.out_ready;
  assign stall    = (state_q == StRun) && hazard && bus.out_ready;
  assign in_ready = bus.flush || !(hold || stall);
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    ill_cnt_d = ill_cnt_q;
    if (bus.flush || (!hold && (stall || !bus.in_valid))) begin
      valid_d   = 1'b0;
      ctrl_d    = '0;
      illegal_d = 1'b0;
      rs1_d     = '0;
      rs2_d     = '0;
      rd_d      = '0;
      state_d   = (!bus.flush && stall) ? StStall : StRun;
    end else if (!hold) begin
      valid_d   = 1'b1;
      ctrl_d    = dec_ctrl;
      illegal_d = dec_illegal;
      rs1_d     = rs1;
      rs2_d     = rs2;
      rd_d      = rd;
      state_d   = StRun;
    end
    if (accept && dec_illegal && (ill_cnt_q != {ILL_CNT_W{1'b1}})) begin
      ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      ill_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.RegWrite  = ctrl_q.reg_write;
  assign bus.ALUSrc    = ctrl_q.alu_src;
  assign bus.MemWrite  = ctrl_q.mem_write;
  assign bus.MemRead   = ctrl_q.mem_read;
  assign bus.Branch    = ctrl_q.branch;
  assign bus.MemToReg  = ctrl_q.mem_to_reg;
  assign bus.ALUop     = ctrl_q.alu_op;
  assign bus.rs1_q     = rs1_q;
  assign bus.rs2_q     = rs2_q;
  assign bus.rd_q      = rd_q;
  assign bus.illegal_q = illegal_q;
  assign bus.ill_cnt   = ill_cnt_q;

endmodule

// File: tb/tb_id_control_pipe.sv
// Directed self-checking bench for id_control_pipe; honours CTRL_JUMP_EN for the JAL vector.
module tb_id_control_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_control_pipe_if #(.REG_ADDR_W(5), .ILL_CNT_W(8)) bus ();

  id_control_pipe #(.OPCODE_W(7), .REG_ADDR_W(5), .ILL_CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

`ifdef CTRL_JUMP_EN
  localparam logic [7:0]  JalBundle  = 8'b1100_1000;
  localparam logic        JalIllegal = 1'b0;
  localparam int unsigned JalCnt     = 0;
`else
  localparam logic [7:0]  JalBundle  = 8'b0000_0000;
  localparam logic        JalIllegal = 1'b1;
  localparam int unsigned JalCnt     = 1;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bundle();
    return {bus.RegWrite, bus.ALUSrc, bus.MemWrite, bus.MemRead, bus.Branch, bus.MemToReg,
            bus.ALUop};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, check in_ready before the edge, then advance one cycle.
  task automatic send(input logic [31:0] ins, input logic exp_rdy, input string tag);
    bus.in_valid = 1'b1;
    bus.instr    = ins;
    #1;
    check_eq({tag, "_rdy"}, 32'(bus.in_ready), 32'(exp_rdy));
    step();
  endtask

  logic [31:0] s_ins [5];
  logic [7:0]  s_exp [5];
  logic [4:0]  s_rd  [5];

  initial begin
    s_ins = '{32'h002081B3, 32'h00508213, 32'h00012383, 32'h0030A223, 32'h00208063};
    s_exp = '{8'b1000_0010, 8'b1100_0011, 8'b1101_0100, 8'b0110_0000, 8'b0000_1001};
    s_rd  = '{5'd3, 5'd4, 5'd7, 5'd4, 5'd0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_eq("rst_valid", 32'(bus.out_valid), 0);
    check_eq("rst_bundle", 32'(bundle()), 0);
    check_eq("rst_rd", 32'(bus.rd_q), 0);
    check_eq("rst_illegal", 32'(bus.illegal_q), 0);
    check_eq("rst_cnt", 32'(bus.ill_cnt), 0);
    check_eq("rst_rdy", 32'(bus.in_ready), 1);

    // add x3,x1,x2 then a back-to-back stream of every base class.
    for (int i = 0; i < 5; i++) begin
      send(s_ins[i], 1'b1, $sformatf("strm%0d", i));
      check_eq($sformatf("strm%0d_valid", i), 32'(bus.out_valid), 1);
      check_eq($sformatf("strm%0d_bundle", i), 32'(bundle()), 32'(s_exp[i]));
      check_eq($sformatf("strm%0d_rd", i), 32'(bus.rd_q), 32'(s_rd[i]));
    end
    check_eq("add_rs1", 32'(bus.rs1_q), 1);
    check_eq("beq_rs2", 32'(bus.rs2_q), 2);

    // lw x5,0(x1) then add x6,x5,x2: one bubble.
    send(32'h0000A283, 1'b1, "lw5");
    check_eq("lw5_rd", 32'(bus.rd_q), 5);
    send(32'h00228333, 1'b0, "haz");
    check_eq("haz_bubble_valid", 32'(bus.out_valid), 0);
    check_eq("haz_bubble_bundle", 32'(bundle()), 0);
    send(32'h00228333, 1'b1, "haz_retry");
    check_eq("haz_add_valid", 32'(bus.out_valid), 1);
    check_eq("haz_add_rd", 32'(bus.rd_q), 6);
    check_eq("haz_add_bundle", 32'(bundle()), 32'h82);

    // Load to x0 never stalls; I-ALU whose rs2 field matches rd_q does not stall either.
    send(32'h0000A003, 1'b1, "lw0");
    send(32'h00200333, 1'b1, "x0_add");
    check_eq("x0_add_valid", 32'(bus.out_valid), 1);
    send(32'h0000A283, 1'b1, "lw5b");
    send(32'h00508313, 1'b1, "addi_rs2field");
    check_eq("addi_bundle", 32'(bundle()), 32'hC3);

    bus.in_valid = 1'b0;
    step();
    check_eq("idle_bubble", 32'(bus.out_valid), 0);
    send(32'h00508313, 1'b1, "addi2");

    // Hold for three cycles, then flush out of the hold.
    bus.out_ready = 1'b0;
    bus.instr     = 32'h002081B3;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("hold%0d_rdy", i), 32'(bus.in_ready), 0);
      step();
      check_eq($sformatf("hold%0d_valid", i), 32'(bus.out_valid), 1);
      check_eq($sformatf("hold%0d_bundle", i), 32'(bundle()), 32'hC3);
      check_eq($sformatf("hold%0d_rd", i), 32'(bus.rd_q), 6);
    end
    bus.flush = 1'b1;
    #1;
    check_eq("flush_rdy", 32'(bus.in_ready), 1);
    step();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    check_eq("flush_valid", 32'(bus.out_valid), 0);
    check_eq("flush_bundle", 32'(bundle()), 0);

    send(32'h0000006F, 1'b1, "jal");
    check_eq("jal_bundle", 32'(bundle()), 32'(JalBundle));
    check_eq("jal_illegal", 32'(bus.illegal_q), 32'(JalIllegal));
    check_eq("jal_cnt", 32'(bus.ill_cnt), JalCnt);

    // A flushed illegal opcode is not counted.
    bus.in_valid = 1'b1;
    bus.instr    = 32'h0000007F;
    bus.flush    = 1'b1;
    step();
    bus.flush = 1'b0;
    check_eq("flush_ill_cnt", 32'(bus.ill_cnt), JalCnt);
    check_eq("flush_ill_valid", 32'(bus.out_valid), 0);

    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 4) check_eq("ill_cnt5", 32'(bus.ill_cnt), JalCnt + 5);
    end
    check_eq("ill_sat", 32'(bus.ill_cnt), 255);
    check_eq("ill_flag", 32'(bus.illegal_q), 1);
    check_eq("ill_bundle", 32'(bundle()), 0);
    check_eq("ill_valid", 32'(bus.out_valid), 1);

    // Reset while a stall is pending drops the waiting instruction.
    send(32'h0000A283, 1'b1, "lw5c");
    bus.instr = 32'h00228333;
    #1;
    check_eq("pre_rst_rdy", 32'(bus.in_ready), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_valid", 32'(bus.out_valid), 0);
    check_eq("mid_rst_cnt", 32'(bus.ill_cnt), 0);
    send(32'h00228333, 1'b1, "post_rst");
    check_eq("post_rst_valid", 32'(bus.out_valid), 1);
    check_eq("post_rst_rd", 32'(bus.rd_q), 6);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
